// File: rtl/i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_target_regfile: I2C target with a 7-bit address match and a byte-wide   |
// | register file behind an auto-incrementing pointer.                         |
// | Optional macro: I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter.  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module i2c_target_regfile #(
  parameter logic [6:0] TGT_ADDR = 7'h50,
  parameter int         DEPTH    = 16,
  localparam int        PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_WR_PTR    = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_DATA_ACK  = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  // Synchronizers reset to the idle-bus level so no edge is seen out of reset.
  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
    end
  end

  logic scl_s, sda_s;

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_s2_q};
    sda_hist_d = {sda_hist_q[0], sda_s2_q};
    scl_filt_d = (scl_s2_q & scl_hist_q[0]) | (scl_s2_q & scl_hist_q[1]) |
                 (scl_hist_q[0] & scl_hist_q[1]);
    sda_filt_d = (sda_s2_q & sda_hist_q[0]) | (sda_s2_q & sda_hist_q[1]) |
                 (sda_hist_q[0] & sda_hist_q[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_s2_q;
  assign sda_s = sda_s2_q;
`endif

  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       host_data_q, host_data_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [7:0]       rx_byte;
  logic             byte_done;

  assign rx_byte   = {shift_q[6:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 4'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_d       = mem_q;
    host_data_d = mem_q[host_addr];

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (byte_done) begin
            bit_cnt_d = 4'd0;
            if (rx_byte[7:1] == TGT_ADDR) begin
              busy_d  = 1'b1;
              rw_d    = rx_byte[0];
              state_d = ST_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end

        ST_WR_PTR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (byte_done) begin
            bit_cnt_d = 4'd0;
            ptr_d     = rx_byte[PTR_W-1:0];
            state_d   = ST_PTR_ACK;
          end
        end

        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (byte_done) begin
            bit_cnt_d    = 4'd0;
            mem_d[ptr_q] = rx_byte;
            wr_valid_d   = 1'b1;
            wr_addr_d    = ptr_q;
            wr_data_d    = rx_byte;
            state_d      = ST_DATA_ACK;
          end
        end

        // ACK states: the first SCL fall pulls SDA, the next fall releases it.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              shift_d   = mem_q[ptr_q];
              sda_oe_d  = ~mem_q[ptr_q][7];
              bit_cnt_d = 4'd1;
              state_d   = ST_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_PTR;
            end
          end
        end

        ST_PTR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_DATA;
            end
          end
        end

        ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              state_d  = ST_WR_DATA;
            end
          end
        end

        // bit_cnt counts bits already placed on SDA; 0 means load a fresh byte.
        ST_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              shift_d   = mem_q[ptr_q];
              sda_oe_d  = ~mem_q[ptr_q][7];
              bit_cnt_d = 4'd1;
            end else if (bit_cnt_q < 4'd8) begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_DATA;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end

        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          sda_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      host_data_q <= 8'h00;
      mem_q       <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      host_data_q <= host_data_d;
      mem_q       <= mem_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign host_data = host_data_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_target_regfile: bit-banged I2C master driving i2c_target_regfile.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_i2c_target_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_oe;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] host_addr;
  logic [7:0] host_data;
  logic       busy;
  wire        sda_bus = sda_m & ~sda_oe;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0]  model_mem [16];
  logic [3:0]  model_ptr;
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [11:0] wr_e;

  i2c_target_regfile #(.TGT_ADDR(7'h50), .DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .host_addr(host_addr),
    .host_data(host_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every register-file write the DUT reports must match the next expected one.
  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      if (exp_wr.size() == 0) begin
        check_val("wr_unexpected", 32'(wr_valid), 32'd0);
      end else begin
        wr_e = exp_wr.pop_front();
        check_val("wr_addr", 32'(wr_addr), 32'(wr_e[11:8]));
        check_val("wr_data", 32'(wr_data), 32'(wr_e[7:0]));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  task automatic qwait();
    repeat (4) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
    qwait();
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[7-i]; qwait();
      scl_m = 1'b1;   qwait(); qwait();
      scl_m = 1'b0;   qwait();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_lvl);
    write_bits(b, 8);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    @(negedge clk);
    ack_lvl = sda_bus;
    qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    sda_m = 1'b1;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      qwait();
      scl_m = 1'b1; qwait();
      @(negedge clk);
      d = {d[6:0], sda_bus};
      qwait();
      scl_m = 1'b0;
    end
    qwait();
    sda_m = nack; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
    sda_m = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_lvl, input string tag);
    logic a;
    write_byte(b, a);
    check_val(tag, 32'(a), 32'(exp_lvl));
  endtask

  task automatic set_ptr(input logic [7:0] p);
    send(p, 1'b0, "ack_ptr");
    model_ptr = p[3:0];
  endtask

  task automatic put_data(input logic [7:0] d);
    exp_wr.push_back({model_ptr, d});
    model_mem[model_ptr] = d;
    model_ptr = model_ptr + 4'd1;
    send(d, 1'b0, "ack_data");
  endtask

  task automatic get_data(input logic nack);
    logic [7:0] d;
    exp_rd.push_back(model_mem[model_ptr]);
    read_byte(nack, d);
    check_val("rd_data", 32'(d), 32'(exp_rd.pop_front()));
    if (!nack) model_ptr = model_ptr + 4'd1;
  endtask

  task automatic host_chk(input logic [3:0] idx);
    host_addr = idx;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("host_data", 32'(host_data), 32'(model_mem[idx]));
  endtask

  initial begin
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    host_addr = 4'd0;
    model_ptr = 4'd0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_val("rst_wr_valid", 32'(wr_valid), 32'd0);
    check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_val("rst_wr_data", 32'(wr_data), 32'd0);
    check_val("rst_host_data", 32'(host_data), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Plain write of two bytes starting at register 3.
    i2c_start();
    send(8'hA0, 1'b0, "ack_addr_w");
    @(negedge clk);
    check_val("busy_match", 32'(busy), 32'd1);
    set_ptr(8'h03);
    put_data(8'h11);
    put_data(8'h22);
    i2c_stop();
    @(negedge clk);
    check_val("busy_stop", 32'(busy), 32'd0);
    host_chk(4'd3);
    host_chk(4'd4);

    // Pointer write, repeated START, sequential read ending in NACK.
    i2c_start();
    send(8'hA0, 1'b0, "ack_addr_w");
    set_ptr(8'h03);
    i2c_start();
    send(8'hA1, 1'b0, "ack_addr_r");
    get_data(1'b0);
    get_data(1'b1);
    @(negedge clk);
    check_val("busy_nack", 32'(busy), 32'd0);
    i2c_stop();

    // Foreign address: no ACK, busy stays low, following byte ignored.
    i2c_start();
    send(8'hA2, 1'b1, "nack_addr");
    @(negedge clk);
    check_val("busy_mismatch", 32'(busy), 32'd0);
    send(8'h5A, 1'b1, "nack_after_mismatch");
    i2c_stop();

    // Pointer wrap from DEPTH-1 to 0.
    i2c_start();
    send(8'hA0, 1'b0, "ack_addr_w");
    set_ptr(8'h0F);
    put_data(8'hAA);
    put_data(8'hBB);
    i2c_stop();
    host_chk(4'd15);
    host_chk(4'd0);

    // Upper pointer bits are ignored.
    i2c_start();
    send(8'hA0, 1'b0, "ack_addr_w");
    set_ptr(8'hF2);
    put_data(8'h5C);
    i2c_stop();
    host_chk(4'd2);

    // STOP after half a data byte discards it; next transfer works normally.
    i2c_start();
    send(8'hA0, 1'b0, "ack_addr_w");
    set_ptr(8'h05);
    write_bits(8'hC0, 4);
    i2c_stop();
    host_chk(4'd5);
    i2c_start();
    send(8'hA0, 1'b0, "ack_addr_w");
    set_ptr(8'h06);
    put_data(8'h77);
    i2c_stop();
    host_chk(4'd6);

    // Reset while the target is pulling the address ACK.
    i2c_start();
    write_bits(8'hA0, 8);
    @(negedge clk);
    check_val("ack_drive", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_release", 32'(sda_oe), 32'd0);
    check_val("rst_busy_mid", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_ptr = 4'd0;
    send(8'hA0, 1'b1, "ignored_no_start");
    i2c_stop();
    host_chk(4'd3);
    host_chk(4'd15);

    // Normal write and read-back after the mid-transfer reset.
    i2c_start();
    send(8'hA0, 1'b0, "ack_addr_w");
    set_ptr(8'h01);
    put_data(8'h99);
    i2c_stop();
    i2c_start();
    send(8'hA0, 1'b0, "ack_addr_w");
    set_ptr(8'h01);
    i2c_start();
    send(8'hA1, 1'b0, "ack_addr_r");
    get_data(1'b1);
    i2c_stop();

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("wr_pending", 32'(exp_wr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
